// File: rtl/coeff_ram_streamer_if.sv
// rtl/coeff_ram_streamer_if.sv - load/unload streams and coefficient RAM ports
// Signals:
//   s_valid/s_data/s_ready     load stream into the streamer
//   m_valid/m_data/m_ready     unload stream out of the streamer
//   ram_addr_a/ram_din_a/ram_we_a   RAM write port
//   ram_addr_b/ram_dout_b/ram_we_b  RAM read port (1-cycle synchronous read)
// Modports: master = streamer side, slave = environment/RAM side.
interface coeff_ram_streamer_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  s_valid;
  logic [WIDTH-1:0]      s_data;
  logic                  s_ready;
  logic                  m_valid;
  logic [WIDTH-1:0]      m_data;
  logic                  m_ready;
  logic [ADDR_WIDTH-1:0] ram_addr_a;
  logic [WIDTH-1:0]      ram_din_a;
  logic                  ram_we_a;
  logic [ADDR_WIDTH-1:0] ram_addr_b;
  logic [WIDTH-1:0]      ram_dout_b;
  logic                  ram_we_b;

  modport master (
    input  s_valid, s_data, m_ready, ram_dout_b,
    output s_ready, m_valid, m_data,
    output ram_addr_a, ram_din_a, ram_we_a, ram_addr_b, ram_we_b
  );

  modport slave (
    output s_valid, s_data, m_ready, ram_dout_b,
    input  s_ready, m_valid, m_data,
    input  ram_addr_a, ram_din_a, ram_we_a, ram_addr_b, ram_we_b
  );
endinterface

// File: rtl/coeff_ram_streamer.sv
// rtl/coeff_ram_streamer.sv - streams DEPTH coefficients into or out of a RAM
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start_load, start_unload    single-cycle mode requests, honoured in IDLE only
//   busy                        high while a transfer is in progress
//   done                        one-cycle pulse after the last beat of a transfer
//   bus (master)                load/unload streams and RAM ports
module coeff_ram_streamer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start_load,
  input  logic start_unload,
  output logic busy,
  output logic done,
  coeff_ram_streamer_if.master bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  logic             inflight_q;
  logic [WIDTH-1:0] fifo_mem_q [2];
  logic             fifo_rp_q, fifo_wp_q;
  logic [1:0]       fifo_cnt_q;
  logic             done_q;

  logic       s_ready, m_valid, wr_fire, pop, issue;
  logic       last_write, last_pop, enter_load, enter_unload;
  logic [2:0] occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    enter_load   = 1'b0;
    enter_unload = 1'b0;
    s_ready      = (state_q == LOAD);
    m_valid      = (fifo_cnt_q != 2'd0);
    wr_fire      = bus.s_valid & s_ready;
    pop          = m_valid & bus.m_ready;
    // Reads in flight plus buffered beats, less the one leaving this cycle,
    // must stay below the 2-entry FIFO so a returning read always has a slot.
    occ          = {2'b00, inflight_q} + {1'b0, fifo_cnt_q} - {2'b00, pop};
    issue        = (state_q == UNLOAD) && (rd_cnt_q < DEPTH_C) && (occ < 3'd2);
    last_write   = wr_fire && (wr_cnt_q == LAST_C);
    // All reads issued, none pending, one beat left: this pop is the last.
    last_pop     = pop && (state_q == UNLOAD) && (rd_cnt_q == DEPTH_C)
                   && !inflight_q && (fifo_cnt_q == 2'd1);
    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end else if (start_unload) begin
          state_d      = UNLOAD;
          enter_unload = 1'b1;
        end
      end
      LOAD:    if (last_write) state_d = IDLE;
      UNLOAD:  if (last_pop)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      inflight_q    <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_rp_q     <= 1'b0;
      fifo_wp_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      done_q <= last_write | last_pop;

      if (enter_load)   wr_cnt_q <= '0;
      else if (wr_fire) wr_cnt_q <= wr_cnt_q + 1'b1;

      if (enter_unload) rd_cnt_q <= '0;
      else if (issue)   rd_cnt_q <= rd_cnt_q + 1'b1;

      // RAM data is valid the cycle after the read address was presented.
      inflight_q <= issue;
      if (inflight_q) begin
        fifo_mem_q[fifo_wp_q] <= bus.ram_dout_b;
        fifo_wp_q             <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign bus.s_ready    = s_ready;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = fifo_mem_q[fifo_rp_q];
  assign bus.ram_we_a   = wr_fire;
  assign bus.ram_addr_a = wr_cnt_q[ADDR_WIDTH-1:0];
  // Write data follows the load stream but is forced quiet while in reset.
  assign bus.ram_din_a  = rst ? '0 : bus.s_data;
  assign bus.ram_addr_b = rd_cnt_q[ADDR_WIDTH-1:0];
  assign bus.ram_we_b   = 1'b0;

endmodule

// File: tb/tb_coeff_ram_streamer.sv
// tb/tb_coeff_ram_streamer.sv - directed self-checking bench for coeff_ram_streamer
module tb_coeff_ram_streamer;

  logic clk = 1'b0;
  logic rst;
  logic start_load, start_unload;
  logic busy, done;

  int total = 0;
  int bad   = 0;

  coeff_ram_streamer_if #(.WIDTH(32), .ADDR_WIDTH(8)) bus ();

  coeff_ram_streamer #(.WIDTH(32), .DEPTH(256), .ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_load   (start_load),
    .start_unload (start_unload),
    .busy         (busy),
    .done         (done),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (bus.ram_we_a) ram[bus.ram_addr_a] <= bus.ram_din_a;
    bus.ram_dout_b <= ram[bus.ram_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          beats, cyc, writes, done_seen;
  logic        stalled;
  logic [31:0] held;

  initial begin
    rst          = 1'b1;
    start_load   = 1'b0;
    start_unload = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = 32'hDEAD_BEEF;
    bus.m_ready  = 1'b0;

    // Reset state, with load stream active to prove outputs stay quiet
    repeat (2) @(negedge clk);
    bus.s_valid = 1'b1;
    #1;
    check("rst_busy",   busy,           1'b0);
    check("rst_done",   done,           1'b0);
    check("rst_sready", bus.s_ready,    1'b0);
    check("rst_mvalid", bus.m_valid,    1'b0);
    check("rst_we_a",   bus.ram_we_a,   1'b0);
    check("rst_addr_a", bus.ram_addr_a, 8'd0);
    check("rst_din_a",  bus.ram_din_a,  32'd0);
    check("rst_addr_b", bus.ram_addr_b, 8'd0);
    check("rst_we_b",   bus.ram_we_b,   1'b0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Both starts together: load wins; start_unload during LOAD is ignored
    @(negedge clk);
    start_load   = 1'b1;
    start_unload = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    #1;
    check("prio_busy",   busy,        1'b1);
    check("prio_sready", bus.s_ready, 1'b1);
    check("prio_mvalid", bus.m_valid, 1'b0);
    @(negedge clk);
    start_unload = 1'b0;
    #1;
    check("ign_sready", bus.s_ready,    1'b1);
    check("ign_addr_a", bus.ram_addr_a, 8'd0);
    check("ign_addr_b", bus.ram_addr_b, 8'd0);

    // Full load of i*3 with s_valid held high
    for (int i = 0; i < 256; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = i * 3;
      #1;
      check("ld_we_a",   bus.ram_we_a,   1'b1);
      check("ld_addr_a", bus.ram_addr_a, i[7:0]);
      check("ld_din_a",  bus.ram_din_a,  i * 3);
      check("ld_done",   done,           1'b0);
      check("ld_we_b",   bus.ram_we_b,   1'b0);
      @(negedge clk);
    end
    bus.s_data = 32'd999;
    #1;
    check("ld_end_done",   done,         1'b1);
    check("ld_end_busy",   busy,         1'b0);
    check("ld_end_sready", bus.s_ready,  1'b0);
    check("ld_end_we_a",   bus.ram_we_a, 1'b0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    check("ld_done_once", done, 1'b0);

    // Unload with m_ready held high
    start_unload = 1'b1;
    bus.m_ready  = 1'b1;
    @(negedge clk);
    start_unload = 1'b0;
    #1;
    check("ul_busy",    busy,        1'b1);
    check("ul_mv_e0",   bus.m_valid, 1'b0);
    @(negedge clk);
    check("ul_mv_e1",   bus.m_valid, 1'b0);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      check("ul_mvalid", bus.m_valid, 1'b1);
      check("ul_mdata",  bus.m_data,  k * 3);
      check("ul_done",   done,        1'b0);
    end
    @(negedge clk);
    check("ul_end_done",   done,        1'b1);
    check("ul_end_busy",   busy,        1'b0);
    check("ul_end_mvalid", bus.m_valid, 1'b0);
    @(negedge clk);
    check("ul_done_once", done, 1'b0);

    // Unload with m_ready pattern 1,0,0,1
    start_unload = 1'b1;
    bus.m_ready  = 1'b0;
    @(negedge clk);
    start_unload = 1'b0;
    beats     = 0;
    cyc       = 0;
    done_seen = 0;
    stalled   = 1'b0;
    held      = 32'd0;
    while (beats < 256 && cyc < 3000) begin
      bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      if (stalled) check("tog_stall_hold", bus.m_data, held);
      if (done) done_seen++;
      check("tog_fifo_le2", dut.fifo_cnt_q <= 2'd2, 1'b1);
      if (bus.m_valid && bus.m_ready) begin
        check("tog_mdata", bus.m_data, beats * 3);
        beats++;
      end
      stalled = bus.m_valid && !bus.m_ready;
      held    = bus.m_data;
      cyc++;
      @(negedge clk);
    end
    check("tog_beats",      beats,     256);
    check("tog_done_early", done_seen, 0);
    #1;
    check("tog_end_done", done,        1'b1);
    check("tog_end_busy", busy,        1'b0);
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("tog_done_once", done, 1'b0);

    // Load with s_valid every 3rd cycle, values 1000+n
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    writes = 0;
    cyc    = 0;
    while (writes < 256 && cyc < 1000) begin
      bus.s_valid = ((cyc % 3) == 0);
      bus.s_data  = 1000 + writes;
      #1;
      check("gap_we_a", bus.ram_we_a, bus.s_valid);
      if (bus.s_valid) begin
        check("gap_addr_a", bus.ram_addr_a, writes[7:0]);
        check("gap_din_a",  bus.ram_din_a,  1000 + writes);
        writes++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #1;
    check("gap_writes",   writes,   256);
    check("gap_done",     done,     1'b1);
    check("gap_busy",     busy,     1'b0);
    check("gap_ram_0",    ram[0],   32'd1000);
    check("gap_ram_255",  ram[255], 32'd1255);

    // Reset after 100 load beats, then restart immediately
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = i;
      @(negedge clk);
    end
    check("mid_addr_a", bus.ram_addr_a, 8'd100);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",   busy,           1'b0);
    check("mid_rst_sready", bus.s_ready,    1'b0);
    check("mid_rst_we_a",   bus.ram_we_a,   1'b0);
    check("mid_rst_addr_a", bus.ram_addr_a, 8'd0);
    check("mid_rst_done",   done,           1'b0);
    @(negedge clk);
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    start_load  = 1'b1;
    @(negedge clk);
    start_load  = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd7;
    #1;
    check("restart_busy",   busy,           1'b1);
    check("restart_we_a",   bus.ram_we_a,   1'b1);
    check("restart_addr_a", bus.ram_addr_a, 8'd0);
    @(negedge clk);
    #1;
    check("restart_addr_a1", bus.ram_addr_a, 8'd1);
    bus.s_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coeff_ram_streamer.md
COEFF_RAM_STREAMER -- requirements
Module: coeff_ram_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, coefficient width.
REQ-002 SHALL have parameter DEPTH, default 256, coefficients per transfer.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, log2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports start_load and start_unload  input  1 each  single-cycle mode requests.
REQ-007 SHALL have port busy  output  1  high while not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports s_valid (input, 1), s_data (input, WIDTH) and s_ready (output, 1)  load stream in.
REQ-010 SHALL have ports m_valid (output, 1), m_data (output, WIDTH) and m_ready (input, 1)  unload stream out.
REQ-011 SHALL have ports ram_addr_a (output, ADDR_WIDTH), ram_din_a (output, WIDTH) and ram_we_a (output, 1)  RAM write port.
REQ-012 SHALL have ports ram_addr_b (output, ADDR_WIDTH), ram_dout_b (input, WIDTH) and ram_we_b (output, 1)  RAM read port; 1-cycle synchronous read latency.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, UNLOAD; IDLE->LOAD on start_load, IDLE->UNLOAD on start_unload.
REQ-014 SHALL give start_load priority when both starts are high in IDLE.
REQ-015 SHALL ignore start_load and start_unload outside IDLE.
REQ-016 SHALL drive s_ready=1 only in LOAD.
REQ-017 SHALL drive ram_we_a = s_valid & s_ready, ram_addr_a = wr_cnt, ram_din_a = s_data, all combinationally.
REQ-018 SHALL increment wr_cnt per s handshake, with wr_cnt starting at 0 on LOAD entry.
REQ-019 SHALL, at the edge accepting write DEPTH-1, enter IDLE and assert done for exactly the following cycle.
REQ-020 SHALL hold ram_we_b = 0 at all times.
REQ-021 SHALL never assert ram_we_a outside LOAD.
REQ-022 SHALL, in UNLOAD, issue a read (ram_addr_b = rd_cnt, rd_cnt++) in a cycle iff rd_cnt < DEPTH and (inflight + fifo_count - pop) < 2.
REQ-023 SHALL define pop = m_valid & m_ready for the cycle.
REQ-024 SHALL capture ram_dout_b into a 2-entry output FIFO in the cycle after a read is issued (inflight flag).
REQ-025 SHALL drive m_valid = fifo non-empty and m_data = FIFO head; m_data SHALL be stable while m_valid & !m_ready.
REQ-026 SHALL drop no beat and duplicate no beat under any m_ready pattern; output order SHALL be address 0..DEPTH-1.
REQ-027 SHALL raise the first m_valid two edges after the edge sampling start_unload.
REQ-028 SHALL, with m_ready held 1, sustain one beat per cycle.
REQ-029 SHALL, at the edge accepting the DEPTH-th m beat, enter IDLE and assert done for exactly the following cycle.
REQ-030 SHALL keep ram_addr_b = rd_cnt when no read is issued.
REQ-031 SHALL use ADDR_WIDTH+1-bit counters so the DEPTH terminal count is representable.
REQ-032 SHALL wrap both counters to 0 on the next mode entry.

Reset
REQ-033 SHALL, on rst high (asynchronous), immediately enter IDLE and drive busy=0, done=0, s_ready=0, m_valid=0, ram_we_a=0.
REQ-034 SHALL, on rst high, clear counters to 0, empty the FIFO and clear inflight.
REQ-035 SHALL hold all RAM address and data outputs at 0 during reset.
REQ-036 SHALL abort any transfer in progress on rst mid-operation; RAM contents already written are not rolled back.
REQ-037 SHALL accept a start request on the first edge after rst deasserts.

Verification
REQ-038 SHALL cover: load DEPTH=256 values i*3 with s_valid always 1 -> ram_we_a high 256 consecutive cycles, addr 0..255, done once, busy low after.
REQ-039 SHALL cover: unload after load with m_ready=1 -> m_data sequence 0,3,...,765, one beat per cycle, first m_valid 2 edges after start, done once.
REQ-040 SHALL cover: unload with m_ready toggling 1,0,0,1 pattern -> identical 256-value sequence, m_data stable while stalled, fifo never exceeds 2.
REQ-041 SHALL cover: start_load and start_unload in the same IDLE cycle -> LOAD entered; start_unload during LOAD ignored.
REQ-042 SHALL cover: rst pulsed after 100 load beats -> busy=0 same cycle, s_ready=0; subsequent load restarts at addr 0.
REQ-043 SHALL cover: load with s_valid gaps (valid every 3rd cycle) -> exactly 256 writes, no write when s_valid=0.
